// File: rtl/problema1_led_driver.sv
// LED pin driver: PWM brightness, optional blink and polarity inversion on top
// of the PIO pattern, configured through a 4-register Avalon-MM slave.
module problema1_led_driver #(
    parameter int PRESCALE = 196,
    parameter int LED_W    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [LED_W-1:0] pattern_in,
    output logic [LED_W-1:0] led_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [2:0]       ctrl_q, ctrl_d;
    logic [7:0]       duty_q, duty_d;
    logic [15:0]      blink_div_q, blink_div_d;
    logic [7:0]       duty_active_q, duty_active_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [LED_W-1:0] pattern_q;
    logic [LED_W-1:0] led_q, led_d;

    logic wr_en, wr_div, tick, boundary, pwm_on, gate;

    assign wr_en    = chipselect & ~write_n;
    assign wr_div   = wr_en & (address == 2'd2);
    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick & (pwm_cnt_q == 8'hFF);
    assign pwm_on   = (duty_active_q == 8'hFF) | (pwm_cnt_q < duty_active_q);
    assign gate     = pwm_on & (blink_phase_q | ~ctrl_q[1]);

    always_comb begin
        ctrl_d        = ctrl_q;
        duty_d        = duty_q;
        blink_div_d   = blink_div_q;
        if (wr_en) begin
            case (address)
                2'd0:    ctrl_d      = writedata[2:0];
                2'd1:    duty_d      = writedata[7:0];
                2'd2:    blink_div_d = writedata[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        presc_d       = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // Duty is only sampled at the period boundary so a period never glitches.
        duty_active_d = boundary ? duty_q : duty_active_q;
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wr_div) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (boundary) begin
            if (blink_div_q == 16'd0) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b1;
            end else if (blink_cnt_q == blink_div_q - 16'd1) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
        assign led_d[gi] = (ctrl_q[0] & pattern_q[gi] & gate) ^ ctrl_q[2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            duty_q        <= '0;
            blink_div_q   <= '0;
            duty_active_q <= '0;
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pattern_q     <= '0;
            led_q         <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_q        <= duty_d;
            blink_div_q   <= blink_div_d;
            duty_active_q <= duty_active_d;
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pattern_q     <= pattern_in;
            led_q         <= led_d;
        end
    end

    assign led_out = led_q;

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[2:0]  = ctrl_q;
            2'd1: readdata[7:0]  = duty_q;
            2'd2: readdata[15:0] = blink_div_q;
            default: begin
                readdata[LED_W-1:0] = pattern_q;
                readdata[8]         = blink_phase_q;
                readdata[9]         = pwm_on;
            end
        endcase
    end

endmodule

// File: tb/tb_problema1_led_driver.sv
// Randomized bench for problema1_led_driver: a cycle-count based reference model
// feeds expected LED/readback values into queues drained by a negedge monitor.
module tb_problema1_led_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [5:0]  pattern_in = '0;
    logic [5:0]  led_out;

    int checks = 0;
    int errors = 0;

    problema1_led_driver #(.PRESCALE(P), .LED_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pattern_in(pattern_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    // Reference model: time is the number of clock edges since reset release.
    int          k_m = 0;
    int          n_m = 0;
    logic [2:0]  ctrl_m = '0;
    logic [7:0]  duty_m = '0;
    logic [15:0] div_m = '0;
    logic [7:0]  da_m = '0;
    logic [5:0]  pat_q_m = '0;

    logic [5:0]  exp_q[$];
    logic [1:0]  rd_q[$];

    function automatic bit pwm_on_m();
        int pos;
        pos = (k_m / P) % 256;
        if (da_m == 8'hFF) return 1'b1;
        return pos < int'(da_m);
    endfunction

    function automatic bit phase_m();
        if (div_m == 16'd0) return 1'b1;
        return ((n_m / int'(div_m)) % 2) == 0;
    endfunction

    function automatic logic [5:0] led_m();
        bit g;
        logic [5:0] base;
        g = pwm_on_m() & (phase_m() | ~ctrl_m[1]);
        base = ctrl_m[0] ? (pat_q_m & {6{g}}) : 6'h00;
        return base ^ {6{ctrl_m[2]}};
    endfunction

    function automatic logic [31:0] read_m(logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[2:0]  = ctrl_m;
            2'd1: r[7:0]  = duty_m;
            2'd2: r[15:0] = div_m;
            default: begin
                r[5:0] = pat_q_m;
                r[8]   = phase_m();
                r[9]   = pwm_on_m();
            end
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            k_m = 0; n_m = 0; ctrl_m = '0; duty_m = '0; div_m = '0;
            da_m = '0; pat_q_m = '0;
            exp_q.push_back(6'h00);
        end else begin
            int e;
            bit bnd, wr;
            exp_q.push_back(led_m());
            e   = k_m + 1;
            bnd = (e % (256 * P)) == 0;
            wr  = chipselect && !write_n;
            if (bnd) da_m = duty_m;
            if (wr && address == 2'd2) n_m = 0;
            else if (bnd) n_m++;
            if (wr) begin
                case (address)
                    2'd0: ctrl_m = writedata[2:0];
                    2'd1: duty_m = writedata[7:0];
                    2'd2: div_m  = writedata[15:0];
                    default: ;
                endcase
            end
            pat_q_m = pattern_in;
            k_m = e;
        end
    end

    // Monitor: led_out is compared every cycle, readdata whenever a read is presented.
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            logic [5:0] exp;
            exp = exp_q.pop_front();
            if (!reset_n) exp = 6'h00;
            checks++;
            if (led_out !== exp) begin
                errors++;
                if (errors < 25)
                    $display("FAIL led_out t=%0t got %h want %h", $time, led_out, exp);
            end
        end
        if (rd_q.size() > 0) begin
            logic [1:0]  a;
            logic [31:0] exp32;
            a = rd_q.pop_front();
            exp32 = read_m(a);
            checks++;
            if (readdata !== exp32) begin
                errors++;
                if (errors < 25)
                    $display("FAIL readdata[%0d] t=%0t got %h want %h", a, $time, readdata, exp32);
            end else begin
                $display("read addr%0d = %h", a, readdata);
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("write addr%0d <= %h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; write_n = 1'b1;
        rd_q.push_back(a);
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd_pat);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rnd_pat && ($urandom % 37) == 0) pattern_in = 6'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        address = 2'd3;
        #1;
        checks++;
        if (led_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_led got %h want 00", led_out);
        end
        checks++;
        if (readdata[8] !== 1'b1) begin
            errors++;
            $display("FAIL reset_phase got %b want 1", readdata[8]);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        $display("reset pulse");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int a = 0; a < 4; a++) bus_read(2'(a));

        // Static full-on with changing pattern.
        pattern_in = 6'h2A;
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'hFF);
        idle(1100, 1'b1);

        // PWM 25%, then mid-period duty change.
        pattern_in = 6'h3F;
        bus_write(2'd1, 32'd64);
        idle(2 * 256 * P + 300, 1'b0);
        bus_write(2'd1, 32'd128);
        idle(2 * 256 * P, 1'b0);
        bus_read(2'd3);

        // Blink at divide-by-2, then restart mid-phase.
        bus_write(2'd1, 32'hFF);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'd3);
        idle(5 * 256 * P, 1'b0);
        bus_read(2'd3);
        bus_write(2'd2, 32'd1);
        bus_read(2'd3);
        idle(3 * 256 * P, 1'b0);

        // Reset in the middle of a period.
        idle(333, 1'b0);
        do_reset();
        for (int a = 0; a < 4; a++) bus_read(2'(a));

        // Invert / disable.
        pattern_in = 6'h15;
        bus_write(2'd0, 32'd4);
        idle(20, 1'b0);
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd0);
        idle(1100, 1'b0);
        bus_write(2'd0, 32'd1);
        idle(20, 1'b0);

        // Readback width masking; STATUS is not writable.
        for (int a = 0; a < 4; a++) bus_write(2'(a), 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) bus_read(2'(a));

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            int r;
            r = int'($urandom % 16);
            pattern_in = 6'($urandom);
            if (r < 8) begin
                idle(int'($urandom_range(1, 6)), 1'b0);
            end else if (r < 12) begin
                logic [1:0]  a;
                logic [31:0] d;
                a = 2'($urandom);
                d = $urandom;
                if (a == 2'd2) d[15:0] = 16'($urandom % 4);
                bus_write(a, d);
            end else if (r < 15) begin
                bus_read(2'($urandom));
            end else if (($urandom % 30) == 0) begin
                do_reset();
            end else begin
                idle(1, 1'b0);
            end
        end

        idle(4, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
